// File: rtl/mmio_uart_hub.sv
// mmio_uart_hub: MMIO bridge between a data bus and a UART (RX ring buffer, TX FIFO with drain FSM).
// Define MMIO_UART_OVERFLOW_STAT_EN to add the RX overflow counter at 0xFFFFFFF0.
module mmio_uart_hub #(
    parameter int RX_DEPTH       = 256,
    parameter int TX_DEPTH       = 16,
    parameter bit RX_DROP_OLDEST = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        stall,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  sdata,
    input  logic        tx_busy
);
    localparam int RA = $clog2(RX_DEPTH);
    localparam int TA = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state, state_next;

    logic [7:0]  rx_mem [RX_DEPTH];
    logic [7:0]  tx_mem [TX_DEPTH];
    logic [RA:0] rx_head, rx_tail, rx_count;
    logic [TA:0] tx_head, tx_tail, tx_count;
    logic        rx_full, rx_empty, rx_pop, rx_push, rx_skip, rx_ovf;
    logic        tx_full, tx_write, tx_push, tx_pop, rd_en;
    logic [7:0]  rx_byte;
    logic        unused_wd;

`ifdef MMIO_UART_OVERFLOW_STAT_EN
    logic [15:0] ovf_count;
    always_ff @(posedge clock)
        if (reset || (en && we && addr == 32'hFFFF_FFF0)) ovf_count <= '0;
        else if (rx_ovf && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 1;
`endif

    assign unused_wd = ^wd[31:8];
    assign rd_en     = en && !we;

    // Count never exceeds the depth, so its MSB alone flags full.
    assign rx_count = rx_tail - rx_head;
    assign rx_full  = rx_count[RA];
    assign rx_empty = rx_count == '0;
    assign rx_pop   = rd_en && addr == 32'hFFFF_FFF1 && !rx_empty;
    assign rx_ovf   = rx_valid && rx_full && !rx_pop;
    assign rx_push  = rx_valid && !(rx_ovf && !RX_DROP_OLDEST);
    assign rx_skip  = rx_ovf && RX_DROP_OLDEST;
    assign rx_byte  = rx_empty ? 8'h00 : rx_mem[rx_head[RA-1:0]];

    assign tx_count = tx_tail - tx_head;
    assign tx_full  = tx_count[TA];
    assign tx_write = en && we && addr == 32'hFFFF_FFF4;
    assign tx_pop   = state == START;
    assign stall    = tx_write && tx_full && !tx_pop;
    assign tx_push  = tx_write && !stall;
    assign tx_start = tx_pop;

    always_comb begin
        rd = '0;
        if (rd_en)
            rd = addr == 32'hFFFF_FFF1 ? {24'h0, rx_byte} :
                 addr == 32'hFFFF_FFF2 ? 32'(rx_count) :
                 addr == 32'hFFFF_FFF8 ? 32'(TX_DEPTH) - 32'(tx_count) :
`ifdef MMIO_UART_OVERFLOW_STAT_EN
                 addr == 32'hFFFF_FFF0 ? {16'h0, ovf_count} :
`endif
                 '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (tx_count != '0 && !tx_busy) state_next = START;
            START:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy) state_next = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_head <= '0;
            rx_tail <= '0;
            tx_head <= '0;
            tx_tail <= '0;
            sdata   <= '0;
            state   <= IDLE;
        end else begin
            if (rx_push) rx_tail <= rx_tail + 1;
            if (rx_pop || rx_skip) rx_head <= rx_head + 1;
            if (tx_push) tx_tail <= tx_tail + 1;
            if (tx_pop) tx_head <= tx_head + 1;
            // Latch the head byte on entry to START so it is stable for the whole frame.
            if (state_next == START) sdata <= tx_mem[tx_head[TA-1:0]];
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_tail[RA-1:0]] <= rx_data;
        if (tx_push) tx_mem[tx_tail[TA-1:0]] <= wd[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_hub.sv
// tb_mmio_uart_hub: directed checks of two RX_DEPTH=4 / TX_DEPTH=2 hubs, one per RX overflow policy.
`timescale 1ns/1ps
module tb_mmio_uart_hub;
    localparam logic [31:0] A_OVF = 32'hFFFF_FFF0;
    localparam logic [31:0] A_RXD = 32'hFFFF_FFF1;
    localparam logic [31:0] A_RXC = 32'hFFFF_FFF2;
    localparam logic [31:0] A_TXD = 32'hFFFF_FFF4;
    localparam logic [31:0] A_TXF = 32'hFFFF_FFF8;
`ifdef MMIO_UART_OVERFLOW_STAT_EN
    localparam logic [31:0] OVF2 = 32'd2;
`else
    localparam logic [31:0] OVF2 = 32'd0;
`endif

    logic        clock = 0, reset = 1, en = 0, we = 0, rx_valid = 0, hold = 0;
    logic [31:0] addr = 0, wd = 0;
    logic [7:0]  rx_data = 0;
    logic [31:0] rd_a, rd_b, da, db;
    logic        stall_a, stall_b, tx_start_a, tx_start_b, tx_busy;
    logic [7:0]  sdata_a, sdata_b;
    logic [7:0]  sent [$];
    int          busy_cnt = 0;
    int          n_vec = 0, n_err = 0;

    always #5 clock = ~clock;
    assign tx_busy = hold || busy_cnt != 0;

    mmio_uart_hub #(.RX_DEPTH(4), .TX_DEPTH(2), .RX_DROP_OLDEST(1)) u_a (
        .clock(clock), .reset(reset), .en(en), .we(we), .addr(addr), .wd(wd),
        .rd(rd_a), .stall(stall_a), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_start(tx_start_a), .sdata(sdata_a), .tx_busy(tx_busy));

    mmio_uart_hub #(.RX_DEPTH(4), .TX_DEPTH(2), .RX_DROP_OLDEST(0)) u_b (
        .clock(clock), .reset(reset), .en(en), .we(we), .addr(addr), .wd(wd),
        .rd(rd_b), .stall(stall_b), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_start(tx_start_b), .sdata(sdata_b), .tx_busy(tx_busy));

    // Transmitter model: logs each handed-over byte, then stays busy for three cycles.
    always @(negedge clock) begin
        if (tx_start_a) begin
            sent.push_back(sdata_a);
            busy_cnt = 3;
        end else if (busy_cnt > 0) busy_cnt--;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic rx, input logic [7:0] b);
        en = 1; we = 0; addr = a; rx_valid = rx; rx_data = b;
        #1 da = rd_a; db = rd_b;
        @(posedge clock);
        #1 en = 0; rx_valid = 0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_valid = 1; rx_data = b;
        @(posedge clock);
        #1 rx_valid = 0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        en = 1; we = 1; addr = a; wd = d;
        #1 while (stall_a && n < 200) begin
            @(posedge clock);
            #1 n++;
        end
        check("wr_stall_cleared", stall_a, 0);
        @(posedge clock);
        #1 en = 0; we = 0;
    endtask

    task automatic wait_sent(input int n);
        int t = 0;
        while (sent.size() < n && t < 200) begin
            @(posedge clock);
            #1 t++;
        end
        check("tx_start_count", sent.size(), n);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 0;
        #1 check("rst_stall_a", stall_a, 0);
        check("rst_stall_b", stall_b, 0);
        check("rst_tx_start_a", tx_start_a, 0);
        check("rst_tx_start_b", tx_start_b, 0);
        check("rst_sdata_a", sdata_a, 0);
        check("rst_sdata_b", sdata_b, 0);
        bus_rd(A_RXC, 0, 0); check("rst_rx_count", da, 0);
        bus_rd(A_TXF, 0, 0); check("rst_tx_free", da, 2);
        bus_rd(A_OVF, 0, 0); check("rst_ovf", da, 0);

        for (int i = 1; i <= 3; i++) rx_byte(8'(17 * i));
        bus_rd(A_RXC, 0, 0); check("rx3_count_a", da, 3); check("rx3_count_b", db, 3);
        for (int i = 1; i <= 3; i++) begin
            bus_rd(A_RXD, 0, 0);
            check("rx3_pop_a", da, 32'(17 * i));
            check("rx3_pop_b", db, 32'(17 * i));
        end
        bus_rd(A_RXD, 0, 0); check("rx_empty_pop", da, 0);
        bus_rd(A_RXC, 0, 0); check("rx_empty_count", da, 0);

        for (int i = 1; i <= 6; i++) rx_byte(8'(i));
        bus_rd(A_RXC, 0, 0); check("ovf_count_a", da, 4); check("ovf_count_b", db, 4);
        bus_rd(A_OVF, 0, 0); check("ovf_stat_a", da, OVF2); check("ovf_stat_b", db, OVF2);
        for (int i = 0; i < 4; i++) begin
            bus_rd(A_RXD, 0, 0);
            check("drop_oldest_pop", da, 32'(3 + i));
            check("drop_new_pop", db, 32'(1 + i));
        end
        bus_wr(A_OVF, 32'hDEAD_BEEF);
        bus_rd(A_OVF, 0, 0); check("ovf_cleared", da, 0);

        rx_byte(8'h66);
        bus_rd(32'h7FFF_FFF1, 0, 0); check("unmapped_rd", da, 0);
        bus_rd(32'hFFFF_FFF3, 0, 0); check("unmapped_rd2", da, 0);
        bus_rd(A_RXC, 0, 0); check("unmapped_no_pop", da, 1);

        bus_rd(A_RXD, 1, 8'h55); check("pop_rx_old_head", da, 32'h66);
        bus_rd(A_RXC, 0, 0); check("pop_rx_count", da, 1);
        bus_rd(A_RXD, 0, 0); check("pop_rx_next", da, 32'h55);

        bus_rd(A_RXD, 1, 8'h77); check("empty_pop_rx_rd", da, 0);
        bus_rd(A_RXC, 0, 0); check("empty_pop_rx_count", da, 1);
        bus_rd(A_RXD, 0, 0); check("empty_pop_rx_byte", da, 32'h77);

        for (int i = 0; i < 4; i++) rx_byte(8'(8'h41 + i));
        bus_rd(A_RXD, 1, 8'h99); check("full_pop_rx_a", da, 32'h41); check("full_pop_rx_b", db, 32'h41);
        bus_rd(A_RXC, 0, 0); check("full_pop_count_a", da, 4); check("full_pop_count_b", db, 4);
        bus_rd(A_OVF, 0, 0); check("full_pop_no_ovf", da, 0);
        for (int i = 0; i < 4; i++) begin
            bus_rd(A_RXD, 0, 0);
            check("full_pop_drain_a", da, i < 3 ? 32'(8'h42 + i) : 32'h99);
            check("full_pop_drain_b", db, i < 3 ? 32'(8'h42 + i) : 32'h99);
        end

        hold = 1;
        bus_wr(A_TXD, 32'hA1);
        bus_wr(A_TXD, 32'hA2);
        bus_rd(A_TXF, 0, 0); check("tx_free_full", da, 0);
        en = 1; we = 1; addr = A_TXD; wd = 32'hA3;
        #1 check("tx_stall_full", stall_a, 1);
        @(posedge clock);
        #1 check("tx_stall_held", stall_a, 1);
        hold = 0;
        bus_wr(A_TXD, 32'hA3);
        wait_sent(3);
        repeat (10) @(posedge clock);
        #1 check("tx_single_pulses", sent.size(), 3);
        check("tx_byte0", sent[0], 32'hA1);
        check("tx_byte1", sent[1], 32'hA2);
        check("tx_byte2", sent[2], 32'hA3);
        check("sdata_hold", sdata_a, 32'hA3);
        bus_rd(A_TXF, 0, 0); check("tx_free_after", da, 2);

        bus_wr(A_TXD, 32'hB1);
        wait_sent(4);
        hold = 1;
        bus_wr(A_TXD, 32'hB2);
        bus_wr(A_TXD, 32'hB3);
        repeat (5) @(posedge clock);
        #1 bus_rd(A_TXF, 0, 0); check("tx_free_before_rst", da, 0);
        reset = 1;
        @(posedge clock);
        #1 reset = 0; hold = 0;
        repeat (20) @(posedge clock);
        #1 check("rst_no_tx_start", sent.size(), 4);
        check("rst_sdata_cleared", sdata_a, 0);
        bus_rd(A_TXF, 0, 0); check("rst_tx_free_mid", da, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
